// File: rtl/prog_load_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_load_seq_if
// Purpose  : Instruction-word load channel (valid/ready) from host link to
//            the program-load sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_load_seq_if #(
    parameter int XLEN = 32
);
    logic            load_valid;
    logic [XLEN-1:0] load_data;
    logic            load_last;
    logic            load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface
`default_nettype wire

// File: rtl/prog_load_seq.sv
`default_nettype none
// ============================================================================
// Module   : prog_load_seq
// Purpose  : Streams a program into instruction memory with the core held in
//            reset, then runs the core for a programmable cycle budget.
//            Define NOP_FILL_EN to pad unwritten memory with NOPs after load.
// Revision : 1.0 - initial release
// ============================================================================
module prog_load_seq #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 64,
    parameter int AW       = $clog2(DEPTH),
    parameter int RST_HOLD = 2,
    parameter int CW       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CW-1:0]   run_cycles,
    input  logic            abort,
    prog_load_seq_if.slave  ld,
    output logic            imem_we,
    output logic [AW-1:0]   imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            core_reset,
    output logic            busy,
    output logic            done,
    output logic            trunc,
    output logic [CW-1:0]   cycle_cnt
);

    localparam int      c_HW        = $clog2(RST_HOLD + 1);
    localparam [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);
`ifdef NOP_FILL_EN
    localparam [XLEN-1:0] c_NOP = XLEN'(32'h0000_0013);
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_HOLD = 3'd3,
        S_RUN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_ptr;
    logic [CW-1:0]     r_budget;
    logic [c_HW-1:0]   r_hold_cnt;
    logic              r_we;
    logic [AW-1:0]     r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_core_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_trunc;
    logic [CW-1:0]     r_cycle_cnt;
    logic [CW-1:0]     w_cnt_inc;
    logic              w_budget_hit;

    assign ld.load_ready = (r_state == S_LOAD);

    assign w_cnt_inc    = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + CW'(1);
    assign w_budget_hit = (r_budget != '0) && (w_cnt_inc == r_budget);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_budget     <= '0;
            r_hold_cnt   <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_trunc      <= 1'b0;
            r_cycle_cnt  <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_budget    <= run_cycles;
                        r_trunc     <= 1'b0;
                        r_cycle_cnt <= '0;
                        r_ptr       <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // load_ready is high throughout LOAD, so valid alone is the handshake
                    if (ld.load_valid) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_ptr;
                        r_wdata <= ld.load_data;
                        r_ptr   <= r_ptr + AW'(1);
                        if (r_ptr == c_LAST_ADDR) begin
                            r_trunc    <= !ld.load_last;
                            r_hold_cnt <= '0;
                            r_state    <= S_HOLD;
                        end else if (ld.load_last) begin
`ifdef NOP_FILL_EN
                            r_state    <= S_FILL;
`else
                            r_hold_cnt <= '0;
                            r_state    <= S_HOLD;
`endif
                        end
                    end
                end
`ifdef NOP_FILL_EN
                S_FILL: begin
                    r_we    <= 1'b1;
                    r_addr  <= r_ptr;
                    r_wdata <= c_NOP;
                    r_ptr   <= r_ptr + AW'(1);
                    if (r_ptr == c_LAST_ADDR) begin
                        r_hold_cnt <= '0;
                        r_state    <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    // First HOLD cycle carries the final write; RST_HOLD more follow it
                    if (r_hold_cnt == c_HW'(RST_HOLD)) begin
                        r_core_reset <= 1'b0;
                        r_state      <= S_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HW'(1);
                    end
                end
                S_RUN: begin
                    r_cycle_cnt <= w_cnt_inc;
                    if (abort || w_budget_hit) begin
                        r_core_reset <= 1'b1;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_reset = r_core_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign trunc      = r_trunc;
    assign cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prog_load_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_load_seq
// Purpose  : Directed, table-driven bench for prog_load_seq (DEPTH=8 and
//            DEPTH=4 instances sharing clock and reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_load_seq;

    localparam int c_RST_HOLD = 2;
`ifdef NOP_FILL_EN
    localparam bit c_NOP_ON = 1'b1;
`else
    localparam bit c_NOP_ON = 1'b0;
`endif

    logic clk;
    logic reset;

    // DEPTH=8 instance
    logic        a_start, a_abort, a_we, a_core_reset, a_busy, a_done, a_trunc;
    logic [15:0] a_rc, a_cnt;
    logic [2:0]  a_addr;
    logic [31:0] a_wdata;
    prog_load_seq_if #(.XLEN(32)) lda ();

    // DEPTH=4 instance
    logic        b_start, b_abort, b_we, b_core_reset, b_busy, b_done, b_trunc;
    logic [15:0] b_rc, b_cnt;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    prog_load_seq_if #(.XLEN(32)) ldb ();

    prog_load_seq #(.XLEN(32), .DEPTH(8), .RST_HOLD(c_RST_HOLD), .CW(16)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .run_cycles(a_rc), .abort(a_abort),
        .ld(lda.slave), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .core_reset(a_core_reset), .busy(a_busy), .done(a_done), .trunc(a_trunc),
        .cycle_cnt(a_cnt)
    );

    prog_load_seq #(.XLEN(32), .DEPTH(4), .RST_HOLD(c_RST_HOLD), .CW(16)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .run_cycles(b_rc), .abort(b_abort),
        .ld(ldb.slave), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .core_reset(b_core_reset), .busy(b_busy), .done(b_done), .trunc(b_trunc),
        .cycle_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory/activity monitors, sampled mid-cycle
    logic [31:0] mem_a [8];
    int          wcnt_a [8];
    int          nwr_a, first_wr_a, last_wr_a, low_a, first_low_a;
    logic [31:0] mem_b [4];
    int          wcnt_b [4];
    int          nwr_b;
    int          cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (a_we) begin
            mem_a[a_addr] = a_wdata;
            wcnt_a[a_addr]++;
            nwr_a++;
            if (nwr_a == 1) first_wr_a = cyc;
            last_wr_a = cyc;
        end
        if (!a_core_reset) begin
            if (low_a == 0) first_low_a = cyc;
            low_a++;
        end
        if (b_we) begin
            mem_b[b_addr] = b_wdata;
            wcnt_b[b_addr]++;
            nwr_b++;
        end
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        for (int j = 0; j < 8; j++) begin mem_a[j] = '0; wcnt_a[j] = 0; end
        for (int j = 0; j < 4; j++) begin mem_b[j] = '0; wcnt_b[j] = 0; end
        nwr_a = 0; first_wr_a = 0; last_wr_a = 0; low_a = 0; first_low_a = 0; nwr_b = 0;
        @(negedge clk);
    endtask

    logic [31:0] words [8];

    typedef struct {
        int          nw;        // words in program (last on final word)
        bit          gaps;      // toggle load_valid 1,0,1,0...
        logic [15:0] rc;        // run budget
        int          abort_at;  // RUN cycle to pulse abort in (0 = never)
        int          exp_cnt;   // expected cycle_cnt and core_reset-low cycles
    } scen_t;

    scen_t tbl [5];

    task automatic load_a(input int nw, input bit gaps);
        int  i = 0;
        int  t = 0;
        bit  tog = 1'b1;
        bit  hs;
        while (i < nw && t < 100) begin
            lda.load_valid = gaps ? tog : 1'b1;
            lda.load_data  = words[i];
            lda.load_last  = (i == nw - 1);
            hs = lda.load_valid && lda.load_ready;
            @(negedge clk);
            t++;
            tog = !tog;
            if (hs) i++;
        end
        lda.load_valid = 1'b0;
        lda.load_last  = 1'b0;
        chk("load_a_timeout", (t < 100), 1);
    endtask

    task automatic run_a(input scen_t s);
        int k = 0;
        int t = 0;
        int exp_wr;
        clear_mon();
        a_start = 1'b1;
        a_rc    = s.rc;
        @(negedge clk);
        a_start = 1'b0;
        chk("a_busy_load", a_busy, 1);
        load_a(s.nw, s.gaps);
        while (!a_done && t < 300) begin
            a_abort = 1'b0;
            if (!a_core_reset) begin
                k++;
                if (k == s.abort_at) a_abort = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        a_abort = 1'b0;
        chk("a_done_timeout", (t < 300), 1);
        @(posedge clk);
        #1;
        chk("a_cycle_cnt", a_cnt, 64'(s.exp_cnt));
        chk("a_status", {a_done, a_core_reset, a_busy, a_trunc, lda.load_ready}, 5'b11000);
        chk("a_run_len", low_a, s.exp_cnt);
        chk("a_hold_gap", first_low_a - last_wr_a, c_RST_HOLD + 1);
        exp_wr = c_NOP_ON ? 8 : s.nw;
        chk("a_nwrites", nwr_a, exp_wr);
        if (!s.gaps) chk("a_wr_burst", last_wr_a - first_wr_a + 1, exp_wr);
        for (int j = 0; j < 8; j++) begin
            if (j < s.nw)
                chk($sformatf("a_mem[%0d]", j), {32'(wcnt_a[j]), mem_a[j]}, {32'd1, words[j]});
            else
                chk($sformatf("a_mem[%0d]", j), {32'(wcnt_a[j]), mem_a[j]},
                    c_NOP_ON ? {32'd1, 32'h0000_0013} : 64'd0);
        end
    endtask

    initial begin
        words[0] = 32'h002080B3; words[1] = 32'h002080B3;
        words[2] = 32'h402080B3; words[3] = 32'h0020E1B3;
        words[4] = 32'h0020F1B3; words[5] = 32'h0020A023;
        words[6] = 32'h0000A083; words[7] = 32'h00308093;

        tbl[0] = '{nw: 8, gaps: 1'b0, rc: 16'd8, abort_at: 0,  exp_cnt: 8};
        tbl[1] = '{nw: 4, gaps: 1'b1, rc: 16'd5, abort_at: 0,  exp_cnt: 5};
        tbl[2] = '{nw: 1, gaps: 1'b0, rc: 16'd1, abort_at: 0,  exp_cnt: 1};
        tbl[3] = '{nw: 3, gaps: 1'b0, rc: 16'd0, abort_at: 20, exp_cnt: 20};
        tbl[4] = '{nw: 3, gaps: 1'b0, rc: 16'd3, abort_at: 3,  exp_cnt: 3};

        reset = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_rc = '0;
        b_start = 1'b0; b_abort = 1'b0; b_rc = '0;
        lda.load_valid = 1'b0; lda.load_data = '0; lda.load_last = 1'b0;
        ldb.load_valid = 1'b0; ldb.load_data = '0; ldb.load_last = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ctrl", {a_core_reset, a_we, lda.load_ready, a_busy, a_done, a_trunc}, 6'b100000);
        chk("rst_bus", {a_addr, a_wdata, a_cnt}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ctrl", {a_core_reset, a_busy, a_done, lda.load_ready}, 4'b1000);

        // abort outside RUN must be ignored
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("idle_abort", {a_done, a_busy}, 2'b00);

        for (int s = 0; s < 5; s++) run_a(tbl[s]);

        // Overflow on the DEPTH=4 instance: six words offered, no load_last
        begin
            int hs_n = 0;
            int t = 0;
            bit hs;
            clear_mon();
            b_start = 1'b1;
            b_rc    = 16'd4;
            @(negedge clk);
            b_start = 1'b0;
            while (hs_n < 6 && t < 10) begin
                ldb.load_valid = 1'b1;
                ldb.load_data  = words[hs_n];
                ldb.load_last  = 1'b0;
                hs = ldb.load_ready;
                @(negedge clk);
                t++;
                if (hs) begin
                    hs_n++;
                    if (hs_n == 4) begin
                        chk("b_ready_drop", ldb.load_ready, 0);
                        chk("b_trunc_set", b_trunc, 1);
                    end
                end
            end
            ldb.load_valid = 1'b0;
            chk("b_handshakes", hs_n, 4);
            t = 0;
            while (!b_done && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("b_done_timeout", (t < 100), 1);
            @(posedge clk);
            #1;
            chk("b_end", {b_done, b_trunc, b_core_reset, b_busy}, 4'b1110);
            chk("b_cycle_cnt", b_cnt, 4);
            chk("b_nwrites", nwr_b, 4);
            for (int j = 0; j < 4; j++)
                chk($sformatf("b_mem[%0d]", j), {32'(wcnt_b[j]), mem_b[j]}, {32'd1, words[j]});
            @(negedge clk);
            b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            chk("b_restart", {b_trunc, b_done, b_busy, b_cnt}, {3'b001, 16'd0});
        end

        // Async reset in RUN cycle 3, then confirm the sequencer sits in IDLE
        begin
            int k = 0;
            int t = 0;
            clear_mon();
            a_start = 1'b1;
            a_rc    = 16'd0;
            @(negedge clk);
            a_start = 1'b0;
            load_a(2, 1'b0);
            while (k < 3 && t < 50) begin
                if (!a_core_reset) k++;
                if (k < 3) begin
                    @(negedge clk);
                    t++;
                end
            end
            chk("a_run3_reached", k, 3);
            chk("a_run3_cnt", a_cnt, 2);
            #2;
            reset = 1'b0;
            #1;
            chk("midrun_rst", {a_core_reset, a_busy, a_done, a_cnt}, {3'b100, 16'd0});
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            chk("post_rst_idle", {lda.load_ready, a_busy, a_core_reset}, 3'b001);
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
            chk("post_rst_start", lda.load_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
